serial_subtractor_8bit: RTL and testbench

//  Bit-serial, multi-cycle A - B - Bin unit. It is the inverse-direction companion to the 8-bit ripple-carry adder.
//  It processes one bit per clock, LSB first, using a single 1-bit full subtractor and a borrow flip-flop.
//  It sits beside the adder in the arithmetic datapath and uses a start/busy/done handshake toward its controller.

---
 rtl/sub_pkg.sv | 16 +
 rtl/full_subtractor_1bit.sv | 13 +
 rtl/serial_subtractor_8bit.sv | 101 ++++++++++
 tb/tb_serial_subtractor_8bit.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/sub_pkg.sv
// Shared constants for the bit-serial subtractor: FSM state encoding and default operand width.
package sub_pkg;

  localparam int SUB_WIDTH = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_SHIFT = ST_SHIFT,
    S_DONE  = ST_DONE
  } state_t;

endpackage

// File: rtl/full_subtractor_1bit.sv
// Combinational 1-bit full subtractor: d = a - b - bin, bout = borrow out.
module full_subtractor_1bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor_8bit.sv
// Bit-serial A - B - Bin, LSB first, one bit per clock with a start/busy/done handshake.
// Optional signed-overflow output Ovf is enabled by defining SUB_OVERFLOW_EN.
module serial_subtractor_8bit
  import sub_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout
`ifdef SUB_OVERFLOW_EN
  ,
  output logic             Ovf
`endif
);

  localparam int CW = $clog2(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] r_sr;
  logic [CW-1:0]    cnt;
  logic             br;
  logic             d_bit;
  logic             br_next;
  logic             last_bit;

  full_subtractor_1bit u_fs (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (br),
    .d    (d_bit),
    .bout (br_next)
  );

  assign last_bit = (cnt == CW'(WIDTH - 1));

  // NOTE: all state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      Diff  <= '0;
      Bout  <= 1'b0;
      a_sr  <= '0;
      b_sr  <= '0;
      r_sr  <= '0;
      cnt   <= '0;
      br    <= 1'b0;
`ifdef SUB_OVERFLOW_EN
      Ovf   <= 1'b0;
`endif
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          if (start) begin
            a_sr  <= A;
            b_sr  <= B;
            br    <= Bin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= S_SHIFT;
          end else begin
            state <= S_IDLE;
          end
        end
        S_SHIFT: begin
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          r_sr <= {d_bit, r_sr[WIDTH-1:1]};
          br   <= br_next;
          cnt  <= cnt + 1'b1;
          // Outputs are only written on the final bit so a partial result is never visible.
          if (last_bit) begin
            Diff  <= {d_bit, r_sr[WIDTH-1:1]};
            Bout  <= br_next;
`ifdef SUB_OVERFLOW_EN
            // On the last bit the shift registers present the operand sign bits.
            Ovf   <= (a_sr[0] ^ b_sr[0]) & (d_bit ^ a_sr[0]);
`endif
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor_8bit.sv
// Directed self-checking bench for serial_subtractor_8bit (define SUB_OVERFLOW_EN to also check Ovf).
module tb_serial_subtractor_8bit;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] A;
  logic [7:0] B;
  logic       Bin;
  logic       busy;
  logic       done;
  logic [7:0] Diff;
  logic       Bout;
`ifdef SUB_OVERFLOW_EN
  logic       Ovf;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_subtractor_8bit dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .Bin   (Bin),
    .busy  (busy),
    .done  (done),
    .Diff  (Diff),
    .Bout  (Bout)
`ifdef SUB_OVERFLOW_EN
    ,
    .Ovf   (Ovf)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one start, then verify busy length, latency, result and the single-cycle done pulse.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic bin, input logic [7:0] exp_diff,
                        input logic exp_bout, input logic exp_ovf);
    int cycles;
    int busy_cnt;
    @(negedge clk);
    A = a; B = b; Bin = bin; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cycles = 0;
    busy_cnt = 0;
    while (!done && cycles < 20) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      cycles++;
    end
    check({tag, " latency"}, cycles, 8);
    check({tag, " busy"}, busy_cnt, 8);
    check({tag, " diff"}, Diff, exp_diff);
    check({tag, " bout"}, Bout, exp_bout);
`ifdef SUB_OVERFLOW_EN
    check({tag, " ovf"}, Ovf, exp_ovf);
`else
    if (exp_ovf) begin end
`endif
    @(negedge clk);
    check({tag, " done pulse"}, done, 0);
  endtask

  initial begin
    int done_cnt;
    int first_t;
    int second_t;

    rst = 1'b1; start = 1'b0; A = '0; B = '0; Bin = 1'b0;
    repeat (3) @(negedge clk);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset diff", Diff, 0);
    check("reset bout", Bout, 0);
    rst = 1'b0;

    run_op("t1", 8'h34, 8'h12, 1'b0, 8'h22, 1'b0, 1'b0);
    run_op("t2", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
    run_op("t3", 8'h55, 8'hAA, 1'b1, 8'hAA, 1'b1, 1'b1);

    // start pulses while busy must be ignored
    @(negedge clk);
    A = 8'h34; B = 8'h12; Bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    A = 8'hFF; B = 8'h00; start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      if (done) done_cnt++;
      @(negedge clk);
    end
    check("t4 done count", done_cnt, 1);
    check("t4 diff", Diff, 8'h22);
    check("t4 busy idle", busy, 0);

    // reset in the middle of an operation
    @(negedge clk);
    A = 8'hAA; B = 8'h11; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("t5 busy before rst", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5 rst busy", busy, 0);
    check("t5 rst done", done, 0);
    check("t5 rst diff", Diff, 0);
    repeat (10) @(negedge clk);
    check("t5 stays idle", busy, 0);
    run_op("t5b", 8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0);

    run_op("t6a", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    run_op("t6b", 8'h7F, 8'h01, 1'b0, 8'h7E, 1'b0, 1'b0);

    // start held high through DONE gives back-to-back operations
    @(negedge clk);
    A = 8'h34; B = 8'h12; Bin = 1'b0; start = 1'b1;
    first_t = -1;
    second_t = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) begin
        if (first_t < 0) first_t = i;
        else if (second_t < 0) second_t = i;
      end
    end
    start = 1'b0;
    check("b2b first seen", (first_t >= 0), 1);
    check("b2b spacing", second_t - first_t, 9);
    check("b2b diff", Diff, 8'h22);
    repeat (12) @(negedge clk);
    check("b2b idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
